// File: rtl/mem_arb_pkg.sv
// Shared encodings and limits for the memory port arbiter and its wait counter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Counter preload so that BUSY lasts exactly lat cycles.
  function automatic logic [CNT_W-1:0] lat_to_count(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that paces memory wait cycles; zero_c flags the last one.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;
  logic              cnt_load, cnt_dec, cnt_zero_c;
  logic              dm_wins_tie_c, grant_dm_c;

`ifdef ARB_RR_EN
  // owner_q still names the last grant while idle, so it doubles as the RR pointer.
  assign dm_wins_tie_c = (owner_q == OWN_IF);
`else
  assign dm_wins_tie_c = 1'b1;
`endif

  arb_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (lat_to_count(MEM_LAT)),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      busy_q     <= busy_d;
    end
  end

  // Grant and latch in IDLE, pace BUSY with the counter, single DONE cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    grant_dm_c = dm_req && (!if_req || dm_wins_tie_c);
    case (state_q)
      ARB_IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ARB_BUSY;
          cnt_load = 1'b1;
          if (grant_dm_c) begin
            owner_d = OWN_DM;
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        if (cnt_zero_c) begin
          state_d = ARB_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Output flops follow the state being entered; read data lands on the last wait cycle.
  always_comb begin
    mem_en_d   = (state_d == ARB_BUSY);
    mem_we_d   = (state_d == ARB_BUSY) && we_d;
    if_ack_d   = (state_d == ARB_DONE) && (owner_q == OWN_IF);
    dm_ack_d   = (state_d == ARB_DONE) && (owner_q == OWN_DM);
    busy_d     = (state_d != ARB_IDLE);
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if ((state_q == ARB_BUSY) && cnt_zero_c && !we_q) begin
      if (owner_q == OWN_DM) begin
        dm_rdata_d = mem_rdata;
      end else begin
        if_rdata_d = mem_rdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule
